// File: rtl/l_type_instruction_encoder_pkg.sv
// Shared L-type (load) field widths, opcode/funct3 constants and the bit-packing helper.
package l_type_instruction_encoder_pkg;

  localparam int unsigned IMM_W = 12;
  localparam int unsigned REG_W = 5;
  localparam int unsigned F3_W  = 3;
  localparam int unsigned OP_W  = 7;

  localparam logic [OP_W-1:0] OPCODE_LOAD = 7'b0000011;

  typedef enum logic [F3_W-1:0] {
    F3Lb  = 3'b000,
    F3Lh  = 3'b001,
    F3Lw  = 3'b010,
    F3Ld  = 3'b011,
    F3Lbu = 3'b100,
    F3Lhu = 3'b101,
    F3Lwu = 3'b110
  } l_funct3_e;

  // Pure bit placement: {imm[11:0], rs1, funct3, rd, opcode}, no sign extension.
  function automatic logic [31:0] pack_l_type(input logic [IMM_W-1:0] imm,
                                               input logic [REG_W-1:0] rs1,
                                               input logic [F3_W-1:0]  f3,
                                               input logic [REG_W-1:0] rd,
                                               input logic [OP_W-1:0]  op);
    return {imm, rs1, f3, rd, op};
  endfunction

endpackage

// File: rtl/l_type_instruction_encoder_if.sv
// Loader-side field handshake and memory-side word stream of the L-type encoder.
interface l_type_instruction_encoder_if
  import l_type_instruction_encoder_pkg::*;
#(
  parameter int unsigned SIZE   = 32,
  parameter int unsigned ADDR_W = 64
) ();

  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  immediate;
  logic [REG_W-1:0]  rs1;
  logic [F3_W-1:0]   funct3;
  logic [REG_W-1:0]  rd;
  logic [OP_W-1:0]   op_code;
  logic              out_valid;
  logic              out_ready;
  logic [SIZE-1:0]   out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic [ADDR_W-1:0] word_count;
  logic              error;

  modport master (
    output in_valid, immediate, rs1, funct3, rd, op_code, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, word_count, error
  );

  modport slave (
    input  in_valid, immediate, rs1, funct3, rd, op_code, out_ready,
    output in_ready, out_valid, out_instr, out_addr, word_count, error
  );

endinterface

// File: rtl/l_type_instruction_encoder_instr_fifo.sv
// Synchronous FIFO with flush; pointers wrap naturally, count is one bit wider than them.
module l_type_instruction_encoder_instr_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wptr;
  logic [PtrW-1:0]  r_rptr;
  logic [CntW-1:0]  r_count;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + PtrW'(1);
      if (i_pop)  r_rptr <= r_rptr + PtrW'(1);
      r_count <= r_count + CntW'(i_push) - CntW'(i_pop);
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (i_push && !reset && !i_flush) r_mem[r_wptr] <= i_wdata;
  end

  assign o_rdata = r_mem[r_rptr];
  assign o_count = r_count;
  assign o_full  = (r_count == CntW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/l_type_instruction_encoder.sv
// Packs L-type fields into words, queues them and streams them with auto-incrementing byte
// addresses. Define L_ENC_CHECK_EN to drop illegal field sets and raise a sticky error.
module l_type_instruction_encoder
  import l_type_instruction_encoder_pkg::*;
#(
  parameter int unsigned       SIZE      = 32,
  parameter int unsigned       DEPTH     = 4,
  parameter int unsigned       ADDR_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  l_type_instruction_encoder_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic [31:0]       w_packed;
  logic [SIZE-1:0]   w_rdata;
  logic [CntW-1:0]   w_count;
  logic              w_full;
  logic              w_empty;
  logic              w_accept;
  logic              w_illegal;
  logic              w_push;
  logic              w_pop;
  logic              w_error;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_word_count;

  assign w_packed = pack_l_type(bus.immediate, bus.rs1, bus.funct3, bus.rd, bus.op_code);

  assign w_accept = bus.in_valid && !w_full;
  assign w_push   = w_accept && !w_illegal;
  assign w_pop    = !w_empty && bus.out_ready;

  l_type_instruction_encoder_instr_fifo #(
    .WIDTH (SIZE),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_flush (flush),
    .i_push  (w_push),
    .i_wdata (SIZE'(w_packed)),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

`ifdef L_ENC_CHECK_EN
  logic r_error;

  assign w_illegal = (bus.op_code != OPCODE_LOAD) || (bus.funct3 == 3'b111);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_error <= 1'b0;
    end else if (w_accept && w_illegal) begin
      r_error <= 1'b1;
    end
  end

  assign w_error = r_error;
`else
  assign w_illegal = 1'b0;
  assign w_error   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_addr       <= BASE_ADDR;
      r_word_count <= '0;
    end else if (w_pop) begin
      r_addr       <= r_addr + ADDR_W'(4);
      r_word_count <= r_word_count + ADDR_W'(1);
    end
  end

  assign bus.in_ready   = (w_count < CntW'(DEPTH));
  assign bus.out_valid  = !w_empty;
  // Present zero rather than stale storage whenever nothing is queued.
  assign bus.out_instr  = w_empty ? '0 : w_rdata;
  assign bus.out_addr   = r_addr;
  assign bus.word_count = r_word_count;
  assign bus.error      = w_error;

endmodule

// File: tb/tb_l_type_instruction_encoder.sv
// Directed-vector bench for l_type_instruction_encoder with hand-derived expected values.
module tb_l_type_instruction_encoder;

  logic clk = 1'b0;
  logic reset;
  logic flush_a;
  logic flush_b;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  l_type_instruction_encoder_if #(.SIZE(32), .ADDR_W(64)) bus_a ();
  l_type_instruction_encoder_if #(.SIZE(32), .ADDR_W(64)) bus_b ();

  l_type_instruction_encoder #(
    .SIZE      (32),
    .DEPTH     (4),
    .ADDR_W    (64),
    .BASE_ADDR (64'h0)
  ) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .flush (flush_a),
    .bus   (bus_a.slave)
  );

  l_type_instruction_encoder #(
    .SIZE      (32),
    .DEPTH     (4),
    .ADDR_W    (64),
    .BASE_ADDR (64'hFFFF_FFFF_FFFF_FFFC)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .flush (flush_b),
    .bus   (bus_b.slave)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Field generator for vector i (funct3 kept in the legal 0..6 range).
  function automatic logic [11:0] f_imm(input int i); return 12'(i * 37 + 5); endfunction
  function automatic logic [4:0]  f_rs1(input int i); return 5'(i + 1);       endfunction
  function automatic logic [2:0]  f_f3 (input int i); return 3'(i % 7);       endfunction
  function automatic logic [4:0]  f_rd (input int i); return 5'(i * 3 + 2);   endfunction

  function automatic logic [31:0] exp_word(input int i);
    return {f_imm(i), f_rs1(i), f_f3(i), f_rd(i), 7'b0000011};
  endfunction

  task automatic set_a(input int i);
    bus_a.in_valid  = 1'b1;
    bus_a.immediate = f_imm(i);
    bus_a.rs1       = f_rs1(i);
    bus_a.funct3    = f_f3(i);
    bus_a.rd        = f_rd(i);
    bus_a.op_code   = 7'h03;
  endtask

  task automatic set_b(input int i);
    bus_b.in_valid  = 1'b1;
    bus_b.immediate = f_imm(i);
    bus_b.rs1       = f_rs1(i);
    bus_b.funct3    = f_f3(i);
    bus_b.rd        = f_rd(i);
    bus_b.op_code   = 7'h03;
  endtask

  task automatic flush_cycle_a();
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
  endtask

  initial begin
    logic [31:0] word;
    int          n;

    reset   = 1'b1;
    flush_a = 1'b0;
    flush_b = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0;
    bus_a.immediate = '0; bus_a.rs1 = '0; bus_a.funct3 = '0; bus_a.rd = '0; bus_a.op_code = '0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0;
    bus_b.immediate = '0; bus_b.rs1 = '0; bus_b.funct3 = '0; bus_b.rd = '0; bus_b.op_code = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_in_ready",   64'(bus_a.in_ready),  64'd1);
    check("rst_out_valid",  64'(bus_a.out_valid), 64'd0);
    check("rst_out_instr",  64'(bus_a.out_instr), 64'd0);
    check("rst_out_addr",   bus_a.out_addr,       64'd0);
    check("rst_word_count", bus_a.word_count,     64'd0);
    check("rst_error",      64'(bus_a.error),     64'd0);
    check("rst_b_addr",     bus_b.out_addr,       64'hFFFF_FFFF_FFFF_FFFC);
    reset = 1'b0;

    // Test 1: single word, hand-packed value
    bus_a.in_valid  = 1'b1;
    bus_a.immediate = 12'h32B;
    bus_a.rs1       = 5'd14;
    bus_a.funct3    = 3'b011;
    bus_a.rd        = 5'd13;
    bus_a.op_code   = 7'h03;
    bus_a.out_ready = 1'b1;
    #1;
    check("t1_no_comb_path", 64'(bus_a.out_valid), 64'd0);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    check("t1_out_valid", 64'(bus_a.out_valid), 64'd1);
    check("t1_out_instr", 64'(bus_a.out_instr), 64'h32B7_3683);
    check("t1_out_addr",  bus_a.out_addr,       64'd0);
    word = bus_a.out_instr;
    check("t1_dec_fields", {39'd0, word[31:20], word[19:15], word[14:12], word[11:7]},
          {39'd0, 12'h32B, 5'd14, 3'b011, 5'd13});
    @(negedge clk);
    check("t1_drained",    64'(bus_a.out_valid), 64'd0);
    check("t1_addr_inc",   bus_a.out_addr,       64'd4);
    check("t1_word_count", bus_a.word_count,     64'd1);

    flush_cycle_a();
    check("fl_addr",  bus_a.out_addr,   64'd0);
    check("fl_count", bus_a.word_count, 64'd0);

    // Test 2: fill with out_ready low, fifth push held off, drain in order
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t2_ready_before", 64'(bus_a.in_ready), 64'd1);
      set_a(10 + i);
      @(negedge clk);
    end
    check("t2_full_ready", 64'(bus_a.in_ready), 64'd0);
    set_a(14);
    @(negedge clk);
    check("t2_held_ready", 64'(bus_a.in_ready),  64'd0);
    check("t2_stable",     64'(bus_a.out_instr), 64'(exp_word(10)));
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("t2_drain_valid", 64'(bus_a.out_valid), 64'd1);
      check("t2_drain_instr", 64'(bus_a.out_instr), 64'(exp_word(10 + i)));
      check("t2_drain_addr",  bus_a.out_addr,       64'(4 * i));
      @(negedge clk);
    end
    check("t2_empty",      64'(bus_a.out_valid), 64'd0);
    check("t2_word_count", bus_a.word_count,     64'd4);

    // Test 3: steady push+pop with two words queued
    flush_cycle_a();
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_a(20 + i);
      @(negedge clk);
    end
    bus_a.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("t3_instr", 64'(bus_a.out_instr), 64'(exp_word(20 + k)));
      check("t3_addr",  bus_a.out_addr,       64'(4 * k));
      set_a(22 + k);
      @(negedge clk);
    end
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b0;
    check("t3_word_count", bus_a.word_count, 64'd20);
    check("t3_final_addr", bus_a.out_addr,   64'd80);
    bus_a.out_ready = 1'b1;
    n = 0;
    while (bus_a.out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    check("t3_residual", 64'(n), 64'd2);

    // Test 4: address wrap from the top of the address space
    for (int i = 0; i < 2; i++) begin
      set_b(40 + i);
      @(negedge clk);
    end
    bus_b.in_valid = 1'b0;
    check("t4_addr_top", bus_b.out_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    bus_b.out_ready = 1'b1;
    @(negedge clk);
    check("t4_addr_wrap",  bus_b.out_addr,        64'd0);
    check("t4_instr_2nd",  64'(bus_b.out_instr),  64'(exp_word(41)));
    @(negedge clk);
    check("t4_word_count", bus_b.word_count,      64'd2);
    check("t4_empty",      64'(bus_b.out_valid),  64'd0);

    // Test 5: flush, then reset, with three words queued
    flush_cycle_a();
    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_a(50 + i);
      @(negedge clk);
    end
    check("t5_queued", 64'(bus_a.out_valid), 64'd1);
    set_a(53);
    bus_a.out_ready = 1'b1;
    flush_a = 1'b1;
    @(negedge clk);
    flush_a = 1'b0;
    bus_a.in_valid = 1'b0;
    check("t5_fl_valid", 64'(bus_a.out_valid), 64'd0);
    check("t5_fl_addr",  bus_a.out_addr,       64'd0);
    check("t5_fl_wc",    bus_a.word_count,     64'd0);
    repeat (3) @(negedge clk);
    check("t5_fl_quiet", 64'(bus_a.out_valid), 64'd0);

    bus_a.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_a(60 + i);
      @(negedge clk);
    end
    bus_a.out_ready = 1'b1;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    check("t5_pre_rst_addr", bus_a.out_addr, 64'd4);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t5_rst_valid", 64'(bus_a.out_valid), 64'd0);
    check("t5_rst_addr",  bus_a.out_addr,       64'd0);
    check("t5_rst_wc",    bus_a.word_count,     64'd0);
    check("t5_rst_ready", 64'(bus_a.in_ready),  64'd1);

    // Test 6: non-load opcode
    set_a(70);
    bus_a.op_code = 7'h13;
    check("t6_ready", 64'(bus_a.in_ready), 64'd1);
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    bus_a.out_ready = 1'b0;
`ifdef L_ENC_CHECK_EN
    check("t6_no_word", 64'(bus_a.out_valid), 64'd0);
    check("t6_error",   64'(bus_a.error),     64'd1);
    repeat (2) @(negedge clk);
    check("t6_sticky",  64'(bus_a.error),     64'd1);
    set_a(71);
    bus_a.funct3 = 3'b111;
    @(negedge clk);
    bus_a.in_valid = 1'b0;
    check("t6_f3_drop", 64'(bus_a.out_valid), 64'd0);
    flush_cycle_a();
    check("t6_cleared", 64'(bus_a.error),     64'd0);
`else
    check("t6_word",    64'(bus_a.out_valid), 64'd1);
    check("t6_instr",   64'(bus_a.out_instr),
          64'({f_imm(70), f_rs1(70), f_f3(70), f_rd(70), 7'h13}));
    check("t6_error",   64'(bus_a.error),     64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
